serial_addsub_n: RTL and testbench

//  Parametrised bit-serial adder/subtractor: operands enter LSB-first, one bit pair per clock.

---
 rtl/serial_pkg.sv | 20 ++
 rtl/serial_addsub_n_if.sv | 27 ++
 rtl/serial_fa_cell.sv | 41 ++++
 rtl/serial_addsub_n.sv | 125 ++++++++++++
 tb/tb_serial_addsub_n.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state type and
// a single-bit full adder used by the serial datapaths.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Returns {carry, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        logic s;
        logic co;
        s  = a ^ b ^ c;
        co = (a & b) | (a & c) | (b & c);
        return {co, s};
    endfunction

endpackage

// File: rtl/serial_addsub_n_if.sv
// Handshake and data bundle of serial_addsub_n; slave is the adder side,
// master is the side that feeds operands and consumes the result.
interface serial_addsub_n_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic             carryin;
    logic             a_bit;
    logic             b_bit;
    logic             busy;
    logic             sum_bit;
    logic [WIDTH-1:0] y;
    logic             carryout;
    logic             overflow;
    logic             done;

    modport master (
        output start, sub, carryin, a_bit, b_bit,
        input  busy, sum_bit, y, carryout, overflow, done
    );

    modport slave (
        input  start, sub, carryin, a_bit, b_bit,
        output busy, sum_bit, y, carryout, overflow, done
    );
endinterface

// File: rtl/serial_fa_cell.sv
// Full adder with a registered carry: load presets the carry, clr zeroes it,
// en advances it by one bit position.
module serial_fa_cell
    import serial_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic load_val_i,
    input  logic clr_i,
    input  logic en_i,
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_next_o
);
    logic       c_q;
    logic       c_d;
    logic [1:0] fa;

    assign fa       = full_add(a_i, b_i, c_q);
    assign s_o      = fa[0];
    assign c_next_o = fa[1];

    always_comb begin
        c_d = c_q;
        if (load_i)
            c_d = load_val_i;
        else if (clr_i)
            c_d = 1'b0;
        else if (en_i)
            c_d = fa[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            c_q <= 1'b0;
        else
            c_q <= c_d;
    end
endmodule

// File: rtl/serial_addsub_n.sv
// Bit-serial WIDTH-bit adder/subtractor, LSB first, start/done handshake.
// Define SERIAL_ADDSUB_OVF_EN to build the signed-overflow flag; otherwise it reads 0.
module serial_addsub_n
    import serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_addsub_n_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             sum_bit_q, sum_bit_d;
    logic             carryout_q, carryout_d;
    logic             sub_q, sub_d;

    logic accept, run, last, b_eff, s, c_next;
    logic busy, done;

    assign accept = bus.start && ((state_q == IDLE) || (state_q == DONE));
    assign run    = (state_q == RUN);
    assign last   = run && (count_q == CNT_W'(WIDTH - 1));
    assign b_eff  = bus.b_bit ^ sub_q;

    // Subtraction is a + ~b + ~borrow_in, so the carry preset is inverted.
    serial_fa_cell u_fa (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept),
        .load_val_i (bus.sub ? ~bus.carryin : bus.carryin),
        .clr_i      ((state_q == DONE) && !bus.start),
        .en_i       (run),
        .a_i        (bus.a_bit),
        .b_i        (b_eff),
        .s_o        (s),
        .c_next_o   (c_next)
    );

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: if (bus.start) state_d = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = bus.start ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d    = count_q;
        y_d        = y_q;
        sum_bit_d  = sum_bit_q;
        carryout_d = carryout_q;
        sub_d      = sub_q;
        if (accept) begin
            count_d = '0;
            sub_d   = bus.sub;
        end
        if (run) begin
            y_d       = {s, y_q[WIDTH-1:1]};
            sum_bit_d = s;
            count_d   = count_q + CNT_W'(1);
        end
        if (last)
            carryout_d = c_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            y_q        <= '0;
            sum_bit_q  <= 1'b0;
            carryout_q <= 1'b0;
            sub_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            y_q        <= y_d;
            sum_bit_q  <= sum_bit_d;
            carryout_q <= carryout_d;
            sub_q      <= sub_d;
        end
    end

`ifdef SERIAL_ADDSUB_OVF_EN
    logic ovf_q, ovf_d;

    // Carry into the MSB is recovered from the sum: c = s ^ a ^ b.
    always_comb begin
        ovf_d = ovf_q;
        if (last)
            ovf_d = (s ^ bus.a_bit ^ b_eff) ^ c_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_q <= 1'b0;
        else
            ovf_q <= ovf_d;
    end

    assign bus.overflow = ovf_q;
`else
    assign bus.overflow = 1'b0;
`endif

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.y        = y_q;
    assign bus.sum_bit  = sum_bit_q;
    assign bus.carryout = carryout_q;
endmodule

// File: tb/tb_serial_addsub_n.sv
// Scoreboard bench for serial_addsub_n (WIDTH=8); overflow expectations
// follow SERIAL_ADDSUB_OVF_EN.
module tb_serial_addsub_n;
    import serial_pkg::*;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] y;
        logic         c;
        logic         v;
        string        name;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   done_seen = 0;
    int   n_pushed  = 0;

    serial_addsub_n_if #(.WIDTH(W)) bus ();

    serial_addsub_n #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic exp_ovf(input logic v);
`ifdef SERIAL_ADDSUB_OVF_EN
        return v;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            exp_t e;
            done_seen++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
                e = q.pop_front();
                chk({e.name, "_y"}, 32'(bus.y), 32'(e.y));
                chk({e.name, "_carryout"}, 32'(bus.carryout), 32'(e.c));
                chk({e.name, "_overflow"}, 32'(bus.overflow), 32'(e.v));
            end
        end
    end

    // Called at #1 after a rising edge; returns in the DONE cycle.
    task automatic op(input string nm, input logic sub_v, input logic cin_v,
                      input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                      input logic [W-1:0] ey, input logic ec, input logic ev,
                      input int glitch_k);
        exp_t e;
        e.y = ey; e.c = ec; e.v = exp_ovf(ev); e.name = nm;
        q.push_back(e);
        n_pushed++;
        bus.start = 1'b1; bus.sub = sub_v; bus.carryin = cin_v;
        @(posedge clk); #1;
        chk({nm, "_busy"}, 32'(bus.busy), 32'd1);
        for (int k = 0; k < W; k++) begin
            bus.a_bit = a_v[k];
            bus.b_bit = b_v[k];
            bus.start = (k == glitch_k);
            bus.sub     = (k == glitch_k) ? ~sub_v : 1'b0;
            bus.carryin = (k == glitch_k) ? ~cin_v : 1'b0;
            @(posedge clk); #1;
        end
        bus.start = 1'b0; bus.sub = 1'b0; bus.carryin = 1'b0;
        bus.a_bit = 1'b0; bus.b_bit = 1'b0;
        chk({nm, "_done"}, 32'(bus.done), 32'd1);
        chk({nm, "_sum_bit"}, 32'(bus.sum_bit), 32'(ey[W-1]));
    endtask

    task automatic idle_chk(input string nm);
        @(posedge clk); #1;
        chk({nm, "_done_low"}, 32'(bus.done), 32'd0);
        chk({nm, "_busy_low"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int waited;
        bus.start = 1'b0; bus.sub = 1'b0; bus.carryin = 1'b0;
        bus.a_bit = 1'b0; bus.b_bit = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_y", 32'(bus.y), 32'd0);
        chk("rst_carryout", 32'(bus.carryout), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_sum_bit", 32'(bus.sum_bit), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        op("add_5a_33", 1'b0, 1'b0, 8'h5A, 8'h33, 8'h8D, 1'b0, 1'b1, -1);
        idle_chk("add_5a_33");
        @(posedge clk); #1;
        chk("hold_y", 32'(bus.y), 32'h8D);
        chk("hold_overflow", 32'(bus.overflow), 32'(exp_ovf(1'b1)));

        op("sub_10_20", 1'b1, 1'b0, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0, -1);
        idle_chk("sub_10_20");
        op("add_ff_01", 1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, -1);
        idle_chk("add_ff_01");
        op("add_ff_00_c1", 1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, -1);
        idle_chk("add_ff_00_c1");
        op("sub_05_03_b1", 1'b1, 1'b1, 8'h05, 8'h03, 8'h01, 1'b1, 1'b0, -1);
        idle_chk("sub_05_03_b1");
        op("start_in_run", 1'b0, 1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 3);
        idle_chk("start_in_run");

        // Abort mid-run: no expectation is queued, so any done pulse is flagged.
        bus.start = 1'b1; bus.sub = 1'b0; bus.carryin = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.carryin = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.a_bit = 1'b1; bus.b_bit = 1'b1;
            @(posedge clk); #1;
        end
        chk("abort_busy_before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_y", 32'(bus.y), 32'd0);
        chk("abort_carryout", 32'(bus.carryout), 32'd0);
        chk("abort_overflow", 32'(bus.overflow), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_sum_bit", 32'(bus.sum_bit), 32'd0);
        bus.a_bit = 1'b0; bus.b_bit = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_chk("abort_release");

        op("add_01_01", 1'b0, 1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, -1);
        op("b2b_sub_80_01", 1'b1, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, -1);
        idle_chk("b2b_sub_80_01");

        waited = 0;
        while (q.size() != 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        chk("done_pulses", 32'(done_seen), 32'(n_pushed));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before 100000");
        $fatal(1);
    end
endmodule
